// File: rtl/serial_pattern_gen.sv
// ============================================================================
//  Module   : serial_pattern_gen
//  Purpose  : Shifts a programmable bit pattern out MSB-first, with repeat
//             count and inter-repetition idle gap.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [LEN_W-1:0] c_pat_w = LEN_W'(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PAT_W-1:0]   r_pat,  w_pat_nxt;
    logic [LEN_W-1:0]   r_len,  w_len_nxt;
    logic [CNT_W-1:0]   r_reps, w_reps_nxt;
    logic [GAP_W-1:0]   r_gap,  w_gap_nxt;
    logic [LEN_W-1:0]   r_idx,  w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt,  w_cnt_nxt;
    logic [GAP_W-1:0]   r_gcnt, w_gcnt_nxt;
    logic               w_x_nxt, w_valid_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
    logic               w_len_ok;

    function automatic logic pick(input logic [PAT_W-1:0] v, input logic [LEN_W-1:0] i);
        logic b;
        b = 1'b0;
        for (int k = 0; k < PAT_W; k++) begin
            if (LEN_W'(k) == i) b = v[k];
        end
        return b;
    endfunction

    assign w_len_ok = (len != '0) && (len <= c_pat_w);

    // x is registered, so each branch presents the bit that will be on the line next cycle
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
        w_reps_nxt  = r_reps;
        w_gap_nxt   = r_gap;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_gcnt_nxt  = r_gcnt;
        w_x_nxt     = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (w_len_ok) begin
                        w_pat_nxt   = pattern;
                        w_len_nxt   = len;
                        w_reps_nxt  = reps;
                        w_gap_nxt   = gap;
                        w_idx_nxt   = len - 1'b1;
                        w_cnt_nxt   = '0;
                        w_x_nxt     = pick(pattern, len - 1'b1);
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx != '0) begin
                    w_idx_nxt   = r_idx - 1'b1;
                    w_x_nxt     = pick(r_pat, r_idx - 1'b1);
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if ((r_reps != '0) && (w_cnt_nxt == r_reps)) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_gap == '0) begin
                        w_idx_nxt   = r_len - 1'b1;
                        w_x_nxt     = pick(r_pat, r_len - 1'b1);
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_gcnt_nxt  = r_gap;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gcnt == GAP_W'(1)) begin
                    w_gcnt_nxt  = '0;
                    w_idx_nxt   = r_len - 1'b1;
                    w_x_nxt     = pick(r_pat, r_len - 1'b1);
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_gcnt_nxt = r_gcnt - 1'b1;
                    w_busy_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_reps  <= '0;
            r_gap   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_len   <= w_len_nxt;
            r_reps  <= w_reps_nxt;
            r_gap   <= w_gap_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
            x       <= w_x_nxt;
            x_valid <= w_valid_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            err     <= w_err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
// ============================================================================
//  Module   : tb_serial_pattern_gen
//  Purpose  : Directed vector bench for serial_pattern_gen.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_pattern_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       abort;
    logic       x, x_valid, busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       start;
        logic [7:0] pattern;
        logic [3:0] len;
        logic [3:0] reps;
        logic [3:0] gap;
        logic       abort;
        logic [4:0] exp;   // {x, x_valid, busy, done, err} after the edge
    } vec_t;

    vec_t vecs[$];

    serial_pattern_gen #(
        .PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP_W(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .gap     (gap),
        .abort   (abort),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic s, input logic [7:0] p, input logic [3:0] l,
                       input logic [3:0] r, input logic [3:0] g, input logic a,
                       input logic [4:0] e);
        vec_t v;
        v.start = s; v.pattern = p; v.len = l; v.reps = r; v.gap = g; v.abort = a; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input logic [3:0] g, input logic a);
        start = s; pattern = p; len = l; reps = r; gap = g; abort = a;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {x, x_valid, busy, done, err};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: x/x_valid/busy/done/err got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 8'h00, 4'd0, 4'd0, 4'd0, 0);

        // 4-bit 1011, one rep, no gap
        add(1, 8'h0B, 4, 1, 0, 0, 5'b11100);
        add(0, 8'h0B, 4, 1, 0, 0, 5'b01100);
        add(0, 8'h0B, 4, 1, 0, 0, 5'b11100);
        add(0, 8'h0B, 4, 1, 0, 0, 5'b11100);
        add(0, 8'h0B, 4, 1, 0, 0, 5'b00010);
        add(0, 8'h0B, 4, 1, 0, 0, 5'b00000);
        // 1101 twice with a 3-cycle gap; inputs scrambled mid-run must not matter
        add(1, 8'h0D, 4, 2, 3, 0, 5'b11100);
        add(0, 8'h0D, 4, 2, 3, 0, 5'b11100);
        add(0, 8'hFF, 2, 0, 0, 0, 5'b01100);
        add(0, 8'hFF, 2, 0, 0, 0, 5'b11100);
        add(0, 8'hFF, 2, 0, 0, 0, 5'b00100);
        add(0, 8'hFF, 2, 0, 0, 0, 5'b00100);
        add(0, 8'hFF, 2, 0, 0, 0, 5'b00100);
        add(0, 8'h0D, 4, 2, 3, 0, 5'b11100);
        add(0, 8'h0D, 4, 2, 3, 0, 5'b11100);
        add(0, 8'h0D, 4, 2, 3, 0, 5'b01100);
        add(0, 8'h0D, 4, 2, 3, 0, 5'b11100);
        add(0, 8'h0D, 4, 2, 3, 0, 5'b00010);
        add(0, 8'h0D, 4, 2, 3, 0, 5'b00000);
        // illegal lengths
        add(1, 8'h0B, 0, 1, 0, 0, 5'b00001);
        add(0, 8'h0B, 0, 1, 0, 0, 5'b00000);
        add(1, 8'h0B, 9, 1, 0, 0, 5'b00001);
        add(0, 8'h0B, 9, 1, 0, 0, 5'b00000);
        // abort with start in IDLE
        add(1, 8'h0B, 4, 1, 0, 1, 5'b00000);
        add(0, 8'h0B, 4, 1, 0, 0, 5'b00000);
        // full-width 10100101
        add(1, 8'hA5, 8, 1, 0, 0, 5'b11100);
        add(0, 8'hA5, 8, 1, 0, 0, 5'b01100);
        add(0, 8'hA5, 8, 1, 0, 0, 5'b11100);
        add(0, 8'hA5, 8, 1, 0, 0, 5'b01100);
        add(0, 8'hA5, 8, 1, 0, 0, 5'b01100);
        add(0, 8'hA5, 8, 1, 0, 0, 5'b11100);
        add(0, 8'hA5, 8, 1, 0, 0, 5'b01100);
        add(0, 8'hA5, 8, 1, 0, 0, 5'b11100);
        add(0, 8'hA5, 8, 1, 0, 0, 5'b00010);
        // single-bit pattern, 3 reps, 1-cycle gap
        add(1, 8'h01, 1, 3, 1, 0, 5'b11100);
        add(0, 8'h01, 1, 3, 1, 0, 5'b00100);
        add(0, 8'h01, 1, 3, 1, 0, 5'b11100);
        add(0, 8'h01, 1, 3, 1, 0, 5'b00100);
        add(0, 8'h01, 1, 3, 1, 0, 5'b11100);
        add(0, 8'h01, 1, 3, 1, 0, 5'b00010);
        add(0, 8'h01, 1, 3, 1, 0, 5'b00000);

        #2 reset = 1'b0;
        #1 chk("reset_state", 5'b00000);
        step;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].pattern, vecs[i].len, vecs[i].reps, vecs[i].gap, vecs[i].abort);
            step;
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // continuous 101 then abort
        drive(1, 8'h05, 3, 0, 0, 0);
        step; chk("cont0", 5'b11100);
        drive(0, 8'h05, 3, 0, 0, 0);
        for (int i = 1; i < 10; i++) begin
            step;
            chk($sformatf("cont%0d", i), (i % 3 == 1) ? 5'b01100 : 5'b11100);
        end
        abort = 1'b1;
        step; chk("cont_abort", 5'b00000);
        abort = 1'b0;
        step; chk("cont_after_abort", 5'b00000);

        // abort while in GAP
        drive(1, 8'h01, 1, 0, 2, 0);
        step; chk("gapabort_bit", 5'b11100);
        start = 1'b0;
        step; chk("gapabort_gap", 5'b00100);
        abort = 1'b1;
        step; chk("gapabort_idle", 5'b00000);
        abort = 1'b0;

        // asynchronous reset mid-SEND
        drive(1, 8'h0F, 4, 1, 0, 0);
        step; chk("areset_bit0", 5'b11100);
        start = 1'b0;
        step; chk("areset_bit1", 5'b11100);
        #3 reset = 1'b0;
        #1 chk("areset_immediate", 5'b00000);
        #2 reset = 1'b1;
        step; chk("areset_idle", 5'b00000);

        // start while busy ignored; start in done cycle accepted
        drive(1, 8'h0B, 4, 1, 0, 0);
        step; chk("bb_bit0", 5'b11100);
        drive(1, 8'h00, 4, 1, 0, 0);
        step; chk("bb_midstart", 5'b01100);
        drive(0, 8'h0B, 4, 1, 0, 0);
        step; chk("bb_bit2", 5'b11100);
        step; chk("bb_bit3", 5'b11100);
        step; chk("bb_done", 5'b00010);
        drive(1, 8'h0E, 4, 1, 0, 0);
        step; chk("bb_new0", 5'b11100);
        start = 1'b0;
        step; chk("bb_new1", 5'b11100);
        step; chk("bb_new2", 5'b11100);
        step; chk("bb_new3", 5'b01100);
        step; chk("bb_new_done", 5'b00010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
